writeback_arbiter: RTL
======================

# writeback_arbiter

Writeback stage that sits directly upstream of the 16-entry register file. It merges single-cycle ALU results with buffered results from the multi-cycle FPU into the regfile's single write port, producing registered `wr_en`/`wr_addr`/`wr_data`. It keeps a pending-destination scoreboard so issue logic can stall on registers still awaiting an FPU result. It also forces the ALU to yield when FPU results are starved.

## Interface
- `DEPTH`, default 4: FPU result FIFO entries (power of two, ≥2).
- `STARVE`, default 3: consecutive blocked cycles before `stall_alu` asserts.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_addr`  in  4  ALU destination register.
- `alu_data`  in  16  ALU result.
- `fpu_valid`  in  1  FPU result offered.
- `fpu_ready`  out  1  FIFO can accept; transfer when `fpu_valid && fpu_ready`.
- `fpu_addr`  in  4  FPU destination register.
- `fpu_data`  in  16  FPU result.
- `issue_valid`  in  1  an instruction issues this cycle.
- `issue_is_fpu`  in  1  the issuing instruction targets the FPU.
- `issue_addr`  in  4  destination register of the issuing instruction.
- `chk_addr_0`, `chk_addr_1`  in  4 each  source registers queried by issue.
- `busy_0`, `busy_1`  out  1 each  queried register has an outstanding FPU write.
- `stall_alu`  out  1  ALU must not present a result this cycle.
- `wr_en`  out  1  regfile write enable (registered).
- `wr_addr`  out  4  regfile write address (registered).
- `wr_data`  out  16  regfile write data (registered).

## Operation
- **Reset (`reset`=0, async):**
  - `wr_en`, `wr_addr`, `wr_data`, `stall_alu` = 0.
  - FIFO empty, scoreboard cleared, starve counter 0.
  - `fpu_ready` = 1 and `busy_*` = 0 (derived from cleared state).
  - Reset mid-transfer discards all FIFO contents and pending bits.
- **Select, each cycle:**
  - `alu_valid` has absolute priority.
  - Otherwise, if the FIFO is non-empty, pop its head.
  - Otherwise, nothing is written.
- **Output register:** the selected address/data are registered. `wr_en` is 1 next cycle only if a source was selected and its address ≠ 15. Register 15 is the PC alias and read-only, so a write to address 15 is consumed and dropped with `wr_en`=0.
- **FIFO:**
  - Circular buffer of {addr, data}, with read/write pointers wrapping modulo `DEPTH`.
  - `fpu_ready` = (count < `DEPTH`), combinational from count.
  - A push and a pop in the same cycle leave count unchanged.
  - When full, no push is accepted even if a pop occurs that cycle.
- **Scoreboard:** 15-bit pending vector.
  - Set `pending[issue_addr]` when `issue_valid && issue_is_fpu && issue_addr != 15`.
  - Clear `pending[a]` when a FIFO entry with address `a` is popped.
  - If set and clear hit the same address in the same cycle, set wins.
  - `busy_n = pending[chk_addr_n]`, combinational; `chk_addr_n` = 15 always gives 0.
- **Starvation:**
  - The counter increments each cycle the FIFO is non-empty and `alu_valid`=1.
  - It clears on any pop or when the FIFO is empty.
  - When the counter reaches `STARVE`, `stall_alu` is registered high for exactly one cycle and the counter clears.
  - If the ALU ignores `stall_alu`, the ALU still wins.

## Timing
- **ALU latency:** `alu_valid` in cycle N gives `wr_en`=1 in cycle N+1.
- **FPU latency:** with an empty FIFO and idle ALU, accept in N, pop in N+1, `wr_en` in N+2. Each further cycle of ALU blocking adds one cycle.
- **Pending bit:** set in N+1 after issue in N; clears in the cycle after the pop, i.e. the same cycle `wr_en` is asserted for that write.
- **Throughput:** one regfile write per cycle maximum; FIFO sustains one push and one pop per cycle.
- **Ordering:** FPU results retire in acceptance order; no reordering against other FPU results.

## Test plan
- **ALU only:** alu_valid=1, addr=3, data=16'hBEEF in N -> wr_en=1, wr_addr=3, wr_data=BEEF in N+1; wr_en=0 in N+2.
- **FPU path / r15 drop:**
  - Accept {5, 16'h1234} in N with ALU idle -> wr_en=1, addr 5, data 1234 in N+2.
  - Accept {15, x} -> wr_en stays 0 and FIFO count returns to 0.
- **FIFO full with starvation (`DEPTH`=4, `STARVE`=3):**
  - Hold alu_valid=1 and push 4 FPU results -> fpu_ready=0 after the 4th push.
  - stall_alu pulses 1 cycle after 3 blocked cycles.
  - Dropping alu_valid for that cycle -> the first FPU entry is written next cycle.
- **Scoreboard:**
  - Issue FPU to r7 in N -> busy_0=1 for chk_addr_0=7 from N+1.
  - Result for r7 popped in M -> busy_0=0 in M+1.
  - Issue to r7 in the same cycle as its pop -> busy stays 1.
- **Simultaneous push/pop at count 2 with wrap:** pointers wrap past `DEPTH`-1, count stays 2, and data retires in order.
- **Async reset mid-operation:** reset=0 with 3 FIFO entries and pending bits set -> immediately wr_en=0, busy=0, fpu_ready=1. After release, no stale writes occur.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered FPU results onto the
// single regfile write port, tracks pending FPU destinations, and forces the ALU to yield.
module writeback_arbiter #(
    parameter int DEPTH  = 4,
    parameter int STARVE = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [3:0]  alu_addr,
    input  logic [15:0] alu_data,
    input  logic        fpu_valid,
    output logic        fpu_ready,
    input  logic [3:0]  fpu_addr,
    input  logic [15:0] fpu_data,
    input  logic        issue_valid,
    input  logic        issue_is_fpu,
    input  logic [3:0]  issue_addr,
    input  logic [3:0]  chk_addr_0,
    input  logic [3:0]  chk_addr_1,
    output logic        busy_0,
    output logic        busy_1,
    output logic        stall_alu,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [15:0] wr_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (STARVE > 1) ? $clog2(STARVE + 1) : 1;

    logic [3:0]    fifo_addr [DEPTH];
    logic [15:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [14:0]   pending;
    logic [15:0]   pending_ext;
    logic [14:0]   set_vec;
    logic [14:0]   clr_vec;
    logic [SW-1:0] starve_cnt;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          blocked;
    logic [3:0]    head_addr;
    logic [15:0]   head_data;
    logic          sel_valid;
    logic [3:0]    sel_addr;
    logic [15:0]   sel_data;

    assign fifo_empty = (count == '0);
    assign fpu_ready  = (count < CW'(DEPTH));
    assign push       = fpu_valid && fpu_ready;
    assign pop        = !alu_valid && !fifo_empty;
    assign blocked    = alu_valid && !fifo_empty;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = head_addr;
        sel_data  = head_data;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_addr  = alu_addr;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= fpu_addr;
            fifo_data[wr_ptr] <= fpu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Set is OR-ed in after the clear so a same-cycle reissue keeps the bit.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_is_fpu && issue_addr != 4'd15)
            set_vec = 15'(16'd1 << issue_addr);
        if (pop && head_addr != 4'd15)
            clr_vec = 15'(16'd1 << head_addr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= (pending & ~clr_vec) | set_vec;
    end

    assign pending_ext = {1'b0, pending};
    assign busy_0      = pending_ext[chk_addr_0];
    assign busy_1      = pending_ext[chk_addr_1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            stall_alu  <= 1'b0;
        end else if (blocked) begin
            if (starve_cnt == SW'(STARVE - 1)) begin
                starve_cnt <= '0;
                stall_alu  <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + SW'(1);
                stall_alu  <= 1'b0;
            end
        end else begin
            starve_cnt <= '0;
            stall_alu  <= 1'b0;
        end
    end

    // r15 aliases the PC: a selected write to it is consumed but never enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= sel_valid && (sel_addr != 4'd15);
            if (sel_valid) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

endmodule
